apb_master_arbiter: RTL and testbench

- APB master controller that shares one APB bus between NUM_REQ local requesters.
- Round-robin arbitration picks the requester for each transfer.
- Sequences IDLE->SETUP->ACCESS per the APB protocol and returns read data and error status to the winning requester.
- A wait-state watchdog aborts any transfer whose slave holds pready low too long and reports it as an error, so a hung slave cannot lock the bus.

---
 rtl/apb_master_arbiter.sv | 174 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ local requesters: round-robin grant, IDLE/SETUP/ACCESS
// sequencing, and a wait-state watchdog that aborts transfers stuck on pready=0.
module apb_master_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         done,
  output logic [DATA_W-1:0]          rdata,
  output logic                       err,
  output logic                       timeout,
  output logic                       busy,
  output logic                       psel,
  output logic                       penable,
  output logic                       pwrite,
  output logic [ADDR_W-1:0]          paddr,
  output logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W-1:0]          prdata,
  input  logic                       pready,
  input  logic                       pslverr
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [NUM_REQ-1:0]  done_d;
  logic [DATA_W-1:0]   rdata_d, pwdata_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic                err_d, timeout_d, busy_d, psel_d, penable_d, pwrite_d;

  logic [NUM_REQ-1:0]  eligible;
  logic [GW-1:0]       pick;
  logic                found;
  int unsigned         idx;
  logic                last_wait;
  logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  // A requester is not re-eligible in the cycle its done pulse is shown
  assign eligible  = req & ~done;
  assign last_wait = (wait_cnt_q == CW'(TIMEOUT - 1));

  // Round-robin search upward from last_grant+1
  always_comb begin
    pick  = last_grant_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant_q) + k) % NUM_REQ;
      if (!found && eligible[GW'(idx)]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  // State and output registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      wait_cnt_q   <= '0;
      done         <= '0;
      rdata        <= '0;
      err          <= 1'b0;
      timeout      <= 1'b0;
      busy         <= 1'b0;
      psel         <= 1'b0;
      penable      <= 1'b0;
      pwrite       <= 1'b0;
      paddr        <= '0;
      pwdata       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      done         <= done_d;
      rdata        <= rdata_d;
      err          <= err_d;
      timeout      <= timeout_d;
      busy         <= busy_d;
      psel         <= psel_d;
      penable      <= penable_d;
      pwrite       <= pwrite_d;
      paddr        <= paddr_d;
      pwdata       <= pwdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|eligible) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (pready || last_wait) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    psel_d       = psel;
    penable_d    = penable;
    pwrite_d     = pwrite;
    paddr_d      = paddr;
    pwdata_d     = pwdata;
    done_d       = '0;
    rdata_d      = '0;
    err_d        = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          grant_d   = pick;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = req_write[pick];
          paddr_d   = addr_arr[pick];
          pwdata_d  = req_write[pick] ? wdata_arr[pick] : '0;
        end
      end
      ST_SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end
      ST_ACCESS: begin
        if (pready) begin
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          done_d[grant_q] = 1'b1;
          rdata_d         = pwrite ? '0 : prdata;
          err_d           = pslverr;
          last_grant_d    = grant_q;
        end else if (last_wait) begin
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          done_d[grant_q] = 1'b1;
          err_d           = 1'b1;
          timeout_d       = 1'b1;
          last_grant_d    = grant_q;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: transaction-age reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requesters and slave.
module tb_apb_master_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic              pclk, presetn;
  logic [NR-1:0]     req, req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     done;
  logic [DW-1:0]     rdata, prdata, pwdata;
  logic [AW-1:0]     paddr;
  logic              err, timeout, busy, psel, penable, pwrite, pready, pslverr;

  int n_vec = 0;
  int n_err = 0;

  apb_master_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata),
    .err(err), .timeout(timeout), .busy(busy), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Reference model: a transfer is described by its owner and its age
  // (0 = select cycle, k>=1 = k-th enable cycle).
  bit            m_active;
  int            m_g, m_age, m_last, c;
  bit            found;
  logic [NR-1:0] elig, e_done;
  logic [DW-1:0] e_rdata, e_pwdata;
  logic [AW-1:0] e_paddr;
  logic          e_err, e_to, e_psel, e_pen, e_pwrite;

  task automatic m_finish(input logic er, input logic [DW-1:0] rd, input logic to);
    e_done      = '0;
    e_done[m_g] = 1'b1;
    e_err       = er;
    e_rdata     = rd;
    e_to        = to;
    e_psel      = 1'b0;
    e_pen       = 1'b0;
    m_active    = 1'b0;
    m_last      = m_g;
  endtask

  always @(posedge pclk) begin
    if (!presetn) begin
      m_active = 1'b0; m_g = 0; m_age = 0; m_last = NR - 1;
      e_done = '0; e_rdata = '0; e_err = 1'b0; e_to = 1'b0;
      e_psel = 1'b0; e_pen = 1'b0; e_pwrite = 1'b0; e_paddr = '0; e_pwdata = '0;
    end else begin
      elig = req & ~e_done;
      e_done = '0; e_rdata = '0; e_err = 1'b0; e_to = 1'b0;
      if (!m_active) begin
        found = 1'b0;
        for (int k = 1; k <= NR; k++) begin
          c = (m_last + k) % NR;
          if (!found && elig[c]) begin found = 1'b1; m_g = c; end
        end
        if (found) begin
          m_active = 1'b1; m_age = 0;
          e_psel   = 1'b1; e_pen = 1'b0;
          e_pwrite = req_write[m_g];
          e_paddr  = req_addr[m_g*AW +: AW];
          e_pwdata = req_write[m_g] ? req_wdata[m_g*DW +: DW] : '0;
        end
      end else if (m_age == 0) begin
        m_age = 1; e_pen = 1'b1;
      end else if (pready) begin
        m_finish(pslverr, e_pwrite ? '0 : prdata, 1'b0);
      end else if (m_age == TO) begin
        m_finish(1'b1, '0, 1'b1);
      end else begin
        m_age++;
      end
    end
    #1;
    n_vec++;
    if (done !== e_done || rdata !== e_rdata || err !== e_err || timeout !== e_to ||
        busy !== e_psel || psel !== e_psel || penable !== e_pen || pwrite !== e_pwrite ||
        paddr !== e_paddr || pwdata !== e_pwdata) begin
      n_err++;
      $display("FAIL model t=%0t got done=%b rd=%h err=%b to=%b busy=%b sel=%b en=%b wr=%b a=%h wd=%h exp done=%b rd=%h err=%b to=%b busy=%b sel=%b en=%b wr=%b a=%h wd=%h",
               $time, done, rdata, err, timeout, busy, psel, penable, pwrite, paddr, pwdata,
               e_done, e_rdata, e_err, e_to, e_psel, e_psel, e_pen, e_pwrite, e_paddr, e_pwdata);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    presetn = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) step();
    chk("reset_psel", 64'(psel), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    presetn = 1'b1;
    step();

    // Zero-wait write from requester 0
    pready = 1'b1;
    set_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
    req = 2'b01;
    step();
    chk("zw_setup_psel", 64'(psel), 64'd1);
    chk("zw_setup_pen", 64'(penable), 64'd0);
    chk("zw_paddr", 64'(paddr), 64'h10);
    chk("zw_pwdata", 64'(pwdata), 64'hA5A5_0001);
    step();
    chk("zw_access_pen", 64'(penable), 64'd1);
    step();
    chk("zw_done", 64'(done), 64'b01);
    chk("zw_err", 64'(err), 64'd0);
    chk("zw_psel_low", 64'(psel), 64'd0);
    req = 2'b00;
    step();

    // Read from requester 1 with three wait states
    pready = 1'b0;
    set_req(1, 1'b0, 32'h20, 32'h1111_2222);
    req = 2'b10;
    step();
    chk("rd_setup_paddr", 64'(paddr), 64'h20);
    chk("rd_pwdata_zero", 64'(pwdata), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("rd_wait_paddr", 64'(paddr), 64'h20);
      chk("rd_wait_no_done", 64'(done), 64'd0);
    end
    pready = 1'b1; prdata = 32'hDEAD_BEEF;
    step();
    chk("rd_done", 64'(done), 64'b10);
    chk("rd_rdata", 64'(rdata), 64'hDEAD_BEEF);
    chk("rd_err", 64'(err), 64'd0);
    req = 2'b00; prdata = '0;
    step();
    chk("rd_rdata_clear", 64'(rdata), 64'd0);

    // Round-robin with both requesting continuously
    set_req(0, 1'b1, 32'h30, 32'h0000_0030);
    set_req(1, 1'b1, 32'h34, 32'h0000_0034);
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("rr_psel", 64'(psel), 64'd1);
      step();
      step();
      chk("rr_grant", 64'(done), (t % 2 == 0) ? 64'b01 : 64'b10);
      chk("rr_gap_psel", 64'(psel), 64'd0);
      if (t == 3) req = 2'b00;
    end
    step();

    // Slave error on a write
    set_req(0, 1'b1, 32'h40, 32'h0BAD_0BAD);
    pslverr = 1'b1; req = 2'b01;
    repeat (3) step();
    chk("se_done", 64'(done), 64'b01);
    chk("se_err", 64'(err), 64'd1);
    chk("se_timeout", 64'(timeout), 64'd0);
    req = 2'b00; pslverr = 1'b0;
    step();

    // Watchdog abort after TO enable cycles
    pready = 1'b0; prdata = 32'h5555_AAAA;
    set_req(0, 1'b0, 32'h50, 32'h0);
    req = 2'b01;
    step();
    for (int k = 1; k <= TO; k++) begin
      step();
      chk("wd_hold_pen", 64'(penable), 64'd1);
      chk("wd_no_timeout", 64'(timeout), 64'd0);
    end
    step();
    chk("wd_timeout", 64'(timeout), 64'd1);
    chk("wd_err", 64'(err), 64'd1);
    chk("wd_rdata", 64'(rdata), 64'd0);
    chk("wd_psel", 64'(psel), 64'd0);
    chk("wd_done", 64'(done), 64'b01);
    req = 2'b00;
    step();
    chk("wd_timeout_clear", 64'(timeout), 64'd0);

    // Reset during an enable cycle; the interrupted grant belongs to requester 1
    set_req(0, 1'b1, 32'h60, 32'h6);
    set_req(1, 1'b1, 32'h64, 32'h7);
    req = 2'b11;
    step();
    step();
    chk("rst_pre_pen", 64'(penable), 64'd1);
    presetn = 1'b0;
    #1;
    chk("rst_async_psel", 64'(psel), 64'd0);
    chk("rst_async_pen", 64'(penable), 64'd0);
    chk("rst_async_busy", 64'(busy), 64'd0);
    chk("rst_async_done", 64'(done), 64'd0);
    step();
    step();
    presetn = 1'b1; pready = 1'b1;
    step();
    chk("rst_regrant_psel", 64'(psel), 64'd1);
    step();
    step();
    chk("rst_first_grant", 64'(done), 64'b01);
    req = 2'b00;
    step();

    // pready arrives on the last allowed enable cycle
    pready = 1'b0;
    set_req(1, 1'b0, 32'h70, 32'h0);
    req = 2'b10;
    step();
    for (int k = 1; k <= TO; k++) step();
    pready = 1'b1; prdata = 32'h1234_5678;
    step();
    chk("wd_late_done", 64'(done), 64'b10);
    chk("wd_late_timeout", 64'(timeout), 64'd0);
    chk("wd_late_err", 64'(err), 64'd0);
    chk("wd_late_rdata", 64'(rdata), 64'h1234_5678);
    req = 2'b00;
    step();

    // Randomized requesters and slave
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int mode;
      mode = (cyc / 500) % 3;
      for (int i = 0; i < NR; i++) begin
        if (req[i] && done[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          else set_req(i, 1'($urandom), $urandom, $urandom);
        end else if (req[i]) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, 1'($urandom), $urandom, $urandom);
          req[i] = 1'b1;
        end
      end
      case (mode)
        0:       pready = 1'b1;
        1:       pready = ($urandom_range(0, 1) == 0);
        default: pready = ($urandom_range(0, 19) == 0);
      endcase
      prdata  = $urandom;
      pslverr = ($urandom_range(0, 3) == 0);
      step();
    end

    req = '0;
    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
